// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage with req/ack data-memory FSM and MEM/WB register.
// Define MEM_TIMEOUT_EN to abort accesses after TIMEOUT unacknowledged REQ cycles.
module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWrite_in,
  input  logic [1:0]  MemtoReg_in,
  input  logic        Branch_in,
  input  logic        Jump_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic [31:0] jump_addr_in,
  input  logic [31:0] branch_addr_in,
  input  logic [31:0] PC_plus_4_in,
  input  logic        ALU_zero_in,
  input  logic [31:0] ALU_result_in,
  input  logic [31:0] reg_read_data_2_in,
  input  logic [4:0]  RegisterRd_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        MEM_Stall,
  output logic        PCSrc,
  output logic [31:0] PC_target,
  output logic        RegWrite_out,
  output logic [1:0]  MemtoReg_out,
  output logic [31:0] mem_read_data_out,
  output logic [31:0] ALU_result_out,
  output logic [31:0] PC_plus_4_out,
  output logic [4:0]  RegisterRd_out,
  output logic        mem_err
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t      state;
  logic [31:0] rd_q;
  logic        fail_q;
  logic        mem_op;
  logic        to;
  assign mem_op    = MemRead_in | MemWrite_in;
  // Gated by reset so the upstream pipeline is released as soon as reset asserts.
  assign MEM_Stall = rst & ((state == IDLE & mem_op) | state == REQ);
  assign PCSrc     = Jump_in | (Branch_in & ALU_zero_in);
  assign PC_target = Jump_in ? jump_addr_in : branch_addr_in;
`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  logic          err_q;
  // An ack in the expiring cycle still completes normally.
  assign to      = state == REQ & ~dmem_ack & cnt == CW'(TIMEOUT - 1);
  assign mem_err = err_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      cnt   <= state == REQ ? cnt + 1'b1 : '0;
      err_q <= err_q | to;
    end
  end
`else
  assign to      = 1'b0;
  assign mem_err = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= IDLE;
      dmem_req          <= 1'b0;
      dmem_we           <= 1'b0;
      dmem_addr         <= '0;
      dmem_wdata        <= '0;
      rd_q              <= '0;
      fail_q            <= 1'b0;
      RegWrite_out      <= 1'b0;
      MemtoReg_out      <= '0;
      mem_read_data_out <= '0;
      ALU_result_out    <= '0;
      PC_plus_4_out     <= '0;
      RegisterRd_out    <= '0;
    end else begin
      if (state == IDLE && mem_op) begin
        state      <= REQ;
        dmem_req   <= 1'b1;
        dmem_we    <= MemWrite_in;
        dmem_addr  <= ALU_result_in;
        dmem_wdata <= reg_read_data_2_in;
      end else if (state == REQ && (dmem_ack || to)) begin
        state    <= DONE;
        dmem_req <= 1'b0;
        rd_q     <= to ? 32'hDEAD_BEEF : dmem_we ? 32'h0 : dmem_rdata;
        fail_q   <= to;
      end else if (state == DONE) begin
        state <= IDLE;
      end
      // A stalled cycle writes a bubble so WB never sees the same instruction twice.
      RegWrite_out <= ~MEM_Stall & RegWrite_in & ~(state == DONE & fail_q);
      MemtoReg_out <= MEM_Stall ? 2'b00 : MemtoReg_in;
      if (!MEM_Stall) begin
        mem_read_data_out <= state == DONE ? rd_q : 32'h0;
        ALU_result_out    <= ALU_result_in;
        PC_plus_4_out     <= PC_plus_4_in;
        RegisterRd_out    <= RegisterRd_in;
      end
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage.
// Runs the timeout scenario when MEM_TIMEOUT_EN is defined.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        RegWrite_in = 1'b0;
  logic [1:0]  MemtoReg_in = '0;
  logic        Branch_in = 1'b0;
  logic        Jump_in = 1'b0;
  logic        MemRead_in = 1'b0;
  logic        MemWrite_in = 1'b0;
  logic [31:0] jump_addr_in = '0;
  logic [31:0] branch_addr_in = '0;
  logic [31:0] PC_plus_4_in = '0;
  logic        ALU_zero_in = 1'b0;
  logic [31:0] ALU_result_in = '0;
  logic [31:0] reg_read_data_2_in = '0;
  logic [4:0]  RegisterRd_in = '0;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        MEM_Stall;
  logic        PCSrc;
  logic [31:0] PC_target;
  logic        RegWrite_out;
  logic [1:0]  MemtoReg_out;
  logic [31:0] mem_read_data_out;
  logic [31:0] ALU_result_out;
  logic [31:0] PC_plus_4_out;
  logic [4:0]  RegisterRd_out;
  logic        mem_err;
  int          total = 0;
  int          bad = 0;
  mem_stage dut (
    .clk(clk), .rst(rst), .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in),
    .Branch_in(Branch_in), .Jump_in(Jump_in), .MemRead_in(MemRead_in),
    .MemWrite_in(MemWrite_in), .jump_addr_in(jump_addr_in), .branch_addr_in(branch_addr_in),
    .PC_plus_4_in(PC_plus_4_in), .ALU_zero_in(ALU_zero_in), .ALU_result_in(ALU_result_in),
    .reg_read_data_2_in(reg_read_data_2_in), .RegisterRd_in(RegisterRd_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .MEM_Stall(MEM_Stall), .PCSrc(PCSrc),
    .PC_target(PC_target), .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out),
    .mem_read_data_out(mem_read_data_out), .ALU_result_out(ALU_result_out),
    .PC_plus_4_out(PC_plus_4_out), .RegisterRd_out(RegisterRd_out), .mem_err(mem_err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic nop;
    RegWrite_in = 1'b0;
    MemtoReg_in = 2'b00;
    MemRead_in  = 1'b0;
    MemWrite_in = 1'b0;
    Branch_in   = 1'b0;
    Jump_in     = 1'b0;
  endtask
  task automatic load(input logic [31:0] a, input logic [4:0] rd);
    nop();
    MemRead_in    = 1'b1;
    RegWrite_in   = 1'b1;
    MemtoReg_in   = 2'b01;
    ALU_result_in = a;
    RegisterRd_in = rd;
  endtask
  initial begin
    int n;
    #3;
    check("rst_req", dmem_req, 0);
    check("rst_rw", RegWrite_out, 0);
    check("rst_alu", ALU_result_out, 0);
    check("rst_err", mem_err, 0);
    @(negedge clk) rst = 1'b1;
    // ALU op
    RegWrite_in = 1'b1; RegisterRd_in = 5'd5; ALU_result_in = 32'h10; PC_plus_4_in = 32'h104;
    #1 check("alu_stall", MEM_Stall, 0);
    step();
    check("alu_rw", RegWrite_out, 1);
    check("alu_rd", RegisterRd_out, 5);
    check("alu_res", ALU_result_out, 32'h10);
    check("alu_pc4", PC_plus_4_out, 32'h104);
    check("alu_mrd", mem_read_data_out, 0);
    // load, ack in 2nd REQ cycle
    load(32'h40, 5'd7);
    #1 check("ld_stall_idle", MEM_Stall, 1);
    step();
    check("ld_req", dmem_req, 1);
    check("ld_we", dmem_we, 0);
    check("ld_addr", dmem_addr, 32'h40);
    check("ld_bubble_rw", RegWrite_out, 0);
    check("ld_bubble_m2r", MemtoReg_out, 0);
    check("ld_hold_rd", RegisterRd_out, 5);
    check("ld_stall_req1", MEM_Stall, 1);
    step();
    check("ld_stall_req2", MEM_Stall, 1);
    check("ld_addr2", dmem_addr, 32'h40);
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFEF00D;
    step();
    dmem_ack = 1'b0;
    check("ld_done_req", dmem_req, 0);
    check("ld_done_stall", MEM_Stall, 0);
    step();
    nop();
    check("ld_data", mem_read_data_out, 32'hCAFEF00D);
    check("ld_rw", RegWrite_out, 1);
    check("ld_m2r", MemtoReg_out, 1);
    check("ld_rd", RegisterRd_out, 7);
    // ack outside REQ is ignored
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    check("stray_ack_req", dmem_req, 0);
    check("stray_ack_stall", MEM_Stall, 0);
    // store, ack in 1st REQ cycle
    MemWrite_in = 1'b1; ALU_result_in = 32'h44; reg_read_data_2_in = 32'h1234;
    #1 check("st_stall_idle", MEM_Stall, 1);
    step();
    dmem_ack = 1'b1; dmem_rdata = 32'h5555AAAA;
    check("st_we", dmem_we, 1);
    check("st_wdata", dmem_wdata, 32'h1234);
    check("st_addr", dmem_addr, 32'h44);
    check("st_stall_req", MEM_Stall, 1);
    step();
    dmem_ack = 1'b0;
    check("st_done_stall", MEM_Stall, 0);
    step();
    nop();
    check("st_mrd", mem_read_data_out, 0);
    check("st_rw", RegWrite_out, 0);
    // branch / jump redirect
    Branch_in = 1'b1; ALU_zero_in = 1'b1; branch_addr_in = 32'h80; jump_addr_in = 32'h200;
    #1 check("br_taken", PCSrc, 1);
    check("br_target", PC_target, 32'h80);
    ALU_zero_in = 1'b0;
    #1 check("br_not_taken", PCSrc, 0);
    Branch_in = 1'b0; Jump_in = 1'b1;
    #1 check("jmp_pcsrc", PCSrc, 1);
    check("jmp_target", PC_target, 32'h200);
    nop();
    step();
    // reset during REQ
    load(32'h50, 5'd9);
    step();
    check("rr_req", dmem_req, 1);
    #2 rst = 1'b0;
    #1 check("rr_req_drop", dmem_req, 0);
    check("rr_stall", MEM_Stall, 0);
    check("rr_addr", dmem_addr, 0);
    check("rr_alu", ALU_result_out, 0);
    check("rr_rd", RegisterRd_out, 0);
    @(negedge clk) rst = 1'b1;
    #1 check("rr_restart_stall", MEM_Stall, 1);
    step();
    check("rr_restart_req", dmem_req, 1);
    check("rr_restart_addr", dmem_addr, 32'h50);
    dmem_ack = 1'b1; dmem_rdata = 32'h0BADF00D;
    step();
    dmem_ack = 1'b0;
    step();
    nop();
    check("rr_data", mem_read_data_out, 32'h0BADF00D);
`ifdef MEM_TIMEOUT_EN
    load(32'h60, 5'd3);
    step();
    check("to_req", dmem_req, 1);
    n = 0;
    while (dmem_req && n < 40) begin
      step();
      n++;
    end
    check("to_cycles", n, 16);
    check("to_err", mem_err, 1);
    check("to_stall", MEM_Stall, 0);
    step();
    nop();
    check("to_data", mem_read_data_out, 32'hDEADBEEF);
    check("to_rw", RegWrite_out, 0);
    step();
    check("to_err_sticky", mem_err, 1);
`else
    check("no_err", mem_err, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
